// File: rtl/alu_pkg.sv
// Shared types for the sequential shift-add multiplier: FSM state encoding
// and the select codes understood by the team ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  localparam logic [3:0] ALU_ADD    = 4'b0001;
  localparam logic [3:0] ALU_SHL    = 4'b0011;
  localparam logic [3:0] ALU_SHR    = 4'b0100;
  localparam logic [3:0] ALU_PASS_A = 4'b1000;

endpackage

// File: rtl/alu.sv
// Team ALU: one adder and one barrel shifter behind a select code, with
// zero/negative/overflow flags on the result.
module ALU
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   sel,
  output logic [N-1:0] y,
  output logic         z,
  output logic         n,
  output logic         v
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    y = '0;
    v = 1'b0;
    case (sel)
      ALU_ADD: begin
        y = a + b;
        v = (a[N-1] == b[N-1]) && (y[N-1] != a[N-1]);
      end
      ALU_SHL:    y = a << b;
      ALU_SHR:    y = a >> b;
      ALU_PASS_A: y = a;
      default:    y = '0;
    endcase
    z = (y == '0);
    n = y[N-1];
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential N x N -> N multiplier: shift-add over three states per
// multiplier bit, with every add and shift routed through one shared ALU.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_mcand;
  logic [N-1:0] r_mult;
  logic [N-1:0] r_result;
  logic         r_zero;
  logic         r_ready;
  logic         r_busy;
  logic         r_done;

  logic [N-1:0] w_alu_a;
  logic [N-1:0] w_alu_b;
  logic [3:0]   w_alu_sel;
  logic [N-1:0] w_alu_y;
  logic         w_alu_z;
  logic         w_alu_n;
  logic         w_alu_v;
  logic         w_unused_flags;

  // Operand routing into the shared ALU; the z flag after SHR tells us the
  // multiplier has no set bits left.
  always_comb begin
    w_alu_a   = r_acc;
    w_alu_b   = r_mcand;
    w_alu_sel = ALU_PASS_A;
    case (r_state)
      S_ADD: begin
        w_alu_a   = r_acc;
        w_alu_b   = r_mcand;
        w_alu_sel = r_mult[0] ? ALU_ADD : ALU_PASS_A;
      end
      S_SHL: begin
        w_alu_a   = r_mcand;
        w_alu_b   = ONE;
        w_alu_sel = ALU_SHL;
      end
      S_SHR: begin
        w_alu_a   = r_mult;
        w_alu_b   = ONE;
        w_alu_sel = ALU_SHR;
      end
      default: begin
        w_alu_a   = r_acc;
        w_alu_b   = r_mcand;
        w_alu_sel = ALU_PASS_A;
      end
    endcase
  end

  ALU #(N) u_alu (
    .a   (w_alu_a),
    .b   (w_alu_b),
    .sel (w_alu_sel),
    .y   (w_alu_y),
    .z   (w_alu_z),
    .n   (w_alu_n),
    .v   (w_alu_v)
  );

  assign w_unused_flags = w_alu_n ^ w_alu_v;

  // NOTE: non-blocking assignments so every branch reads pre-edge register values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mult   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_mcand <= op_a;
            r_mult  <= op_b;
            if (op_b == '0) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= '0;
              r_zero   <= 1'b1;
            end else begin
              r_state <= S_ADD;
              r_busy  <= 1'b1;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_ADD: begin
          r_acc   <= w_alu_y;
          r_state <= S_SHL;
          r_busy  <= 1'b1;
        end
        S_SHL: begin
          r_mcand <= w_alu_y;
          r_state <= S_SHR;
          r_busy  <= 1'b1;
        end
        S_SHR: begin
          r_mult <= w_alu_y;
          if (w_alu_z) begin
            // acc was finalised by the preceding ADD, so it is the product.
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= r_acc;
            r_zero   <= (r_acc == '0);
          end else begin
            r_state <= S_ADD;
            r_busy  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed vectors push expected products and DONE
// cycles into a scoreboard that a negedge monitor drains on every done pulse.
module tb_alu_mul_seq;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         zero;

  typedef struct {
    logic [N-1:0] res;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   total;
  int   bad;

  alu_mul_seq #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("zero", 64'(zero), 64'(e.z));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (ready !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) check("ready_timeout", 64'(g), 64'd0);
  endtask

  // Returns the cycle index of the accept edge.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] er, input logic ez, input int lat,
                       output int acc_cyc);
    wait_ready();
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    sb.push_back('{res: er, z: ez, cyc: acc_cyc + lat});
    start = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || ready !== 1'b1) && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) check("drain_timeout", 64'(g), 64'd0);
  endtask

  initial begin
    int c;
    cyc   = 0;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b1;
    op_a  = 32'd9;
    op_b  = 32'd9;

    // Reset with start high: start must be discarded, outputs at reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;

    // 6*7 with busy window check and a stray start at edge 4.
    issue(32'd6, 32'd7, 32'd42, 1'b0, 9, c);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      check("busy_6x7", 64'(busy), 64'd1);
      check("ready_6x7", 64'(ready), 64'd0);
      if (i == 3) begin
        start = 1'b1;
        op_a  = 32'd2;
        op_b  = 32'd2;
      end
      if (i == 4) start = 1'b0;
    end
    @(posedge clk);
    #1;
    check("busy_done_6x7", 64'(busy), 64'd0);
    check("done_6x7", 64'(done), 64'd1);
    drain();

    issue(32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, 96, c);
    drain();
    issue(32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 1'b0, 51, c);
    drain();
    issue(32'd0, 32'd5, 32'd0, 1'b1, 9, c);
    drain();

    // Zero multiplier: DONE straight from the accept edge, ready one edge later.
    issue(32'd123, 32'd0, 32'd0, 1'b1, 0, c);
    check("done_b0", 64'(done), 64'd1);
    check("ready_b0", 64'(ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_b0", 64'(ready), 64'd1);
    drain();

    // 3*255 aborted by reset at edge 12; start during reset is discarded.
    wait_ready();
    start = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd255;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("busy_pre_abort", 64'(busy), 64'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_zero", 64'(zero), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_idle", 64'(ready), 64'd1);

    // start held high: back-to-back 3*1, DONE every five edges.
    wait_ready();
    start = 1'b1;
    op_a  = 32'd3;
    op_b  = 32'd1;
    @(posedge clk);
    #1;
    c = cyc;
    sb.push_back('{res: 32'd3, z: 1'b0, cyc: c + 3});
    sb.push_back('{res: 32'd3, z: 1'b0, cyc: c + 8});
    sb.push_back('{res: 32'd3, z: 1'b0, cyc: c + 13});
    repeat (13) @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, datapath width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request to begin a multiply; sampled only when ready=1.
REQ-005 The block SHALL have ports op_a and op_b  input  N  multiplicand and multiplier, captured on the accept edge.
REQ-006 The block SHALL have port ready  output  1  high only in IDLE.
REQ-007 The block SHALL have port busy  output  1  high in ADD, SHL and SHR.
REQ-008 The block SHALL have port done  output  1  high only in DONE, one cycle per operation.
REQ-009 The block SHALL have port result  output  N  low N bits of op_a*op_b, registered.
REQ-010 The block SHALL have port zero  output  1  registered flag, high when result equals 0.

Function
REQ-011 The block SHALL compute the product by shift-add, time-sharing one internal ALU for every add and shift; no other adder or shifter is allowed.
REQ-012 The FSM SHALL have states IDLE, ADD, SHL, SHR, DONE.
REQ-013 Accept edge (edge 0): state=IDLE and start=1 SHALL load acc=0, mcand=op_a, mult=op_b.
REQ-014 On accept, the next state SHALL be DONE if op_b==0, else ADD.
REQ-015 ADD SHALL drive the ALU with a=acc, b=mcand; sel=ADD if mult[0]=1, else PASS_A; acc <= ALU result; next state SHL.
REQ-016 SHL SHALL drive a=mcand, b=1, sel=SHL; mcand <= ALU result; next state SHR.
REQ-017 SHR SHALL drive a=mult, b=1, sel=SHR; mult <= ALU result; next state DONE if ALU z=1, else ADD.
REQ-018 In IDLE and DONE the ALU select SHALL be PASS_A with a=acc; the ALU output is ignored.
REQ-019 Latency: with k = index of highest set bit of op_b plus 1, the state SHALL become DONE at edge 3k; for op_b==0 it SHALL become DONE at edge 0; the maximum is edge 3N.
REQ-020 On entry to DONE, result SHALL be loaded with the final acc and zero with (final acc==0); both SHALL hold until the next entry to DONE or reset.
REQ-021 DONE SHALL last exactly one cycle, then IDLE; start is ignored during DONE.
REQ-022 Arithmetic SHALL be modulo 2^N; overflow is discarded silently and the result is identical for signed and unsigned interpretation.
REQ-023 start while ready=0 SHALL be ignored, with no effect on state or operands; op_a and op_b changes after edge 0 SHALL have no effect.
REQ-024 With start held high continuously, a new operation SHALL be accepted on the edge after each DONE cycle.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE and clear acc, mcand, mult, result and zero to 0, in any state including mid-operation.
REQ-026 During and after reset, outputs SHALL be ready=1, busy=0, done=0, result=0 and zero=0; zero is 0 after reset, not 1.
REQ-027 A start sampled in the same cycle as rst_n=0 SHALL be discarded.

Structure
REQ-028 Package alu_pkg SHALL hold the state enum and the ALU select constants ALU_ADD=4'b0001, ALU_SHL=4'b0011, ALU_SHR=4'b0100, ALU_PASS_A=4'b1000.
REQ-029 The single sub-module SHALL be the team ALU, instantiated as ALU #(N); its z flag SHALL drive the SHR exit decision; its n and v flags SHALL be left unused.
REQ-030 The three datapath registers and the FSM SHALL live in alu_mul_seq, giving a 120-250 line implementation.

Verification
REQ-031 op_a=6, op_b=7, start pulse -> busy edges 1-8, done in the cycle after edge 9, result=42, zero=0.
REQ-032 op_a=123, op_b=0 -> done in the cycle after edge 0, result=0, zero=1, ready=1 after edge 1.
REQ-033 op_a=32'hFFFF_FFFF, op_b=32'h8000_0000 -> done after edge 96, result=32'h8000_0000.
REQ-034 op_a=0, op_b=5 -> done after edge 9, result=0, zero=1; confirms latency depends on op_b only.
REQ-035 6*7 in flight, start pulsed with op_a=2, op_b=2 at edge 4 -> ignored, result=42; then rst_n=0 at edge 12 of a new 3*255 -> IDLE, result=0, done never asserted.
REQ-036 start held high with op_a=3, op_b=1 -> done after edges 3, 8, 13, ..., result=3 each time.
